// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer : dual-issue circular instruction queue between fetch and decode
// Revision     : 1.0
// ============================================================================
`default_nettype none

module fetch_buffer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid_0,
  input  logic             in_valid_1,
  input  logic [WIDTH-1:0] in_inst_0,
  input  logic [WIDTH-1:0] in_inst_1,
  input  logic [WIDTH-1:0] in_pc,
  output logic             in_ready,
  output logic             out_valid_0,
  output logic             out_valid_1,
  output logic [WIDTH-1:0] inst_0,
  output logic [WIDTH-1:0] inst_1,
  output logic [WIDTH-1:0] pc_0,
  output logic [WIDTH-1:0] pc_1,
  input  logic [1:0]       out_take,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);

  logic [WIDTH-1:0] r_inst_mem [DEPTH];
  logic [WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_head_1;
  logic [PTR_W-1:0] w_tail_1;
  logic [1:0]       w_push_n;
  logic [1:0]       w_take;
  logic [1:0]       w_pop_n;
  logic [WIDTH-1:0] w_pc_1;

  assign w_head_1 = r_head + PTR_ONE;
  assign w_tail_1 = r_tail + PTR_ONE;
  assign w_pc_1   = in_pc + PC_STEP;

  // Readiness looks only at current occupancy; a same-cycle pop never frees room.
  assign in_ready = (r_count <= READY_MAX);

  always_comb begin
    w_push_n = 2'd0;
    if (in_ready && in_valid_0) begin
      w_push_n = in_valid_1 ? 2'd2 : 2'd1;
    end
  end

  // A take of 3 behaves as 2, and the pop never exceeds what is stored.
  assign w_take  = (out_take == 2'd3) ? 2'd2 : out_take;
  assign w_pop_n = (CNT_W'(w_take) > r_count) ? r_count[1:0] : w_take;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_push_n != 2'd0) begin
        r_inst_mem[r_tail] <= in_inst_0;
        r_pc_mem[r_tail]   <= in_pc;
      end
      if (w_push_n == 2'd2) begin
        r_inst_mem[w_tail_1] <= in_inst_1;
        r_pc_mem[w_tail_1]   <= w_pc_1;
      end
    end
  end

  // Invalid slots drive zero so the decoder sees its invalid encoding.
  assign out_valid_0 = (r_count >= CNT_W'(1));
  assign out_valid_1 = (r_count >= CNT_W'(2));
  assign inst_0      = out_valid_0 ? r_inst_mem[r_head]   : '0;
  assign pc_0        = out_valid_0 ? r_pc_mem[r_head]     : '0;
  assign inst_1      = out_valid_1 ? r_inst_mem[w_head_1] : '0;
  assign pc_1        = out_valid_1 ? r_pc_mem[w_head_1]   : '0;
  assign count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// tb_fetch_buffer : directed bench with a queue model of the fetch buffer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid_0;
  logic             in_valid_1;
  logic [WIDTH-1:0] in_inst_0;
  logic [WIDTH-1:0] in_inst_1;
  logic [WIDTH-1:0] in_pc;
  logic             in_ready;
  logic             out_valid_0;
  logic             out_valid_1;
  logic [WIDTH-1:0] inst_0;
  logic [WIDTH-1:0] inst_1;
  logic [WIDTH-1:0] pc_0;
  logic [WIDTH-1:0] pc_1;
  logic [1:0]       out_take;
  logic [CNT_W-1:0] count;

  fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .in_inst_0(in_inst_0), .in_inst_1(in_inst_1), .in_pc(in_pc),
    .in_ready(in_ready),
    .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
    .inst_0(inst_0), .inst_1(inst_1), .pc_0(pc_0), .pc_1(pc_1),
    .out_take(out_take), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] pc;
  } ent_t;

  ent_t q[$];
  bit   model_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: the buffer is an ordered list; pops remove from the front,
  // accepted pushes append at the back.
  task automatic model_update();
    int take;
    int pop;
    bit ready;
    if (rst || flush) begin
      q.delete();
      return;
    end
    ready = (q.size() <= DEPTH - 2);
    take  = (out_take == 2'd3) ? 2 : int'(out_take);
    pop   = (take < q.size()) ? take : q.size();
    for (int i = 0; i < pop; i++) void'(q.pop_front());
    if (ready && in_valid_0) begin
      q.push_back('{inst: in_inst_0, pc: in_pc});
      if (in_valid_1) q.push_back('{inst: in_inst_1, pc: in_pc + 32'd4});
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("cmp_count",   64'(count),       64'(q.size()));
      chk("cmp_ready",   64'(in_ready),    64'(q.size() <= DEPTH - 2));
      chk("cmp_valid_0", 64'(out_valid_0), 64'(q.size() >= 1));
      chk("cmp_valid_1", 64'(out_valid_1), 64'(q.size() >= 2));
      chk("cmp_inst_0",  64'(inst_0), (q.size() >= 1) ? 64'(q[0].inst) : 64'd0);
      chk("cmp_pc_0",    64'(pc_0),   (q.size() >= 1) ? 64'(q[0].pc)   : 64'd0);
      chk("cmp_inst_1",  64'(inst_1), (q.size() >= 2) ? 64'(q[1].inst) : 64'd0);
      chk("cmp_pc_1",    64'(pc_1),   (q.size() >= 2) ? 64'(q[1].pc)   : 64'd0);
    end
  end

  task automatic step(input logic r, input logic f, input logic v0, input logic v1,
                      input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] i1,
                      input logic [WIDTH-1:0] p, input logic [1:0] take);
    rst = r; flush = f; in_valid_0 = v0; in_valid_1 = v1;
    in_inst_0 = i0; in_inst_1 = i1; in_pc = p; out_take = take;
    @(posedge clk);
    model_update();
    model_on = 1'b1;
    #1;
  endtask

  task automatic idle(input logic [1:0] take);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, take);
  endtask

  task automatic dual(input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] i1,
                      input logic [WIDTH-1:0] p, input logic [1:0] take);
    step(1'b0, 1'b0, 1'b1, 1'b1, i0, i1, p, take);
  endtask

  task automatic single(input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] p,
                        input logic [1:0] take);
    step(1'b0, 1'b0, 1'b1, 1'b0, i0, 32'hFFFF_FFFF, p, take);
  endtask

  task automatic do_flush();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 2'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    in_inst_0 = '0; in_inst_1 = '0; in_pc = '0; out_take = 2'd0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 2'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'({out_valid_0, out_valid_1}), 64'd0);
    chk("rst_inst0", 64'(inst_0), 64'd0);

    // First dual push
    dual(32'h0050_0093, 32'h00A0_0113, 32'h100, 2'd0);
    chk("dual_valid", 64'({out_valid_0, out_valid_1}), 64'd3);
    chk("dual_inst0", 64'(inst_0), 64'h0050_0093);
    chk("dual_inst1", 64'(inst_1), 64'h00A0_0113);
    chk("dual_pc0",   64'(pc_0), 64'h100);
    chk("dual_pc1",   64'(pc_1), 64'h104);
    chk("dual_count", 64'(count), 64'd2);

    // Fill to full, then an extra push must be ignored
    do_flush();
    for (int k = 0; k < 4; k++)
      dual(32'h1000 + 32'(2*k), 32'h1001 + 32'(2*k), 32'h200 + 32'(8*k), 2'd0);
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(in_ready), 64'd0);
    dual(32'hDEAD_0000, 32'hDEAD_0001, 32'h900, 2'd0);
    chk("full_hold_count", 64'(count), 64'd8);
    chk("full_hold_inst0", 64'(inst_0), 64'h1000);
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc0",   64'(pc_0),   64'h200 + 64'(8*k));
      chk("drain_inst1", 64'(inst_1), 64'h1001 + 64'(2*k));
      idle(2'd2);
    end
    chk("drain_count", 64'(count), 64'd0);

    // Over-take clamps at count=1
    single(32'h0000_0011, 32'h300, 2'd0);
    chk("one_count", 64'(count), 64'd1);
    chk("one_valid1", 64'(out_valid_1), 64'd0);
    idle(2'd2);
    chk("clamp_count", 64'(count), 64'd0);
    chk("clamp_valid", 64'({out_valid_0, out_valid_1}), 64'd0);
    chk("clamp_insts", 64'({inst_0, inst_1}), 64'd0);

    // PC wrap, take of 3 treated as 2, lone in_valid_1 ignored
    dual(32'h0000_0022, 32'h0000_0033, 32'hFFFF_FFFC, 2'd0);
    chk("wrap_pc1", 64'(pc_1), 64'd0);
    idle(2'd3);
    chk("take3_count", 64'(count), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h55, 32'h500, 2'd0);
    chk("v1_only_count", 64'(count), 64'd0);

    // Steady state across pointer wrap
    dual(32'h2000, 32'h2001, 32'h400, 2'd0);
    dual(32'h2002, 32'h2003, 32'h408, 2'd0);
    for (int j = 1; j <= 10; j++) begin
      dual(32'h2000 + 32'(2*(j+1)), 32'h2001 + 32'(2*(j+1)), 32'h400 + 32'(8*(j+1)), 2'd2);
      chk("steady_count", 64'(count), 64'd4);
      chk("steady_pc0",   64'(pc_0), 64'h400 + 64'(8*j));
      chk("steady_inst0", 64'(inst_0), 64'h2000 + 64'(2*j));
    end

    // Single push at count=7 rejected, accepted at count=6
    do_flush();
    for (int k = 0; k < 3; k++) dual(32'h3000 + 32'(k), 32'h3100 + 32'(k), 32'h600 + 32'(8*k), 2'd0);
    single(32'h3200, 32'h700, 2'd0);
    chk("c7_count", 64'(count), 64'd7);
    chk("c7_ready", 64'(in_ready), 64'd0);
    single(32'h3300, 32'h800, 2'd0);
    chk("c7_reject", 64'(count), 64'd7);
    idle(2'd1);
    chk("c6_count", 64'(count), 64'd6);
    single(32'h3400, 32'h810, 2'd0);
    chk("c6_accept", 64'(count), 64'd7);

    // Flush beats same-cycle push and pop
    do_flush();
    dual(32'h4000, 32'h4001, 32'hA00, 2'd0);
    dual(32'h4002, 32'h4003, 32'hA08, 2'd0);
    single(32'h4004, 32'hA10, 2'd0);
    chk("f5_count", 64'(count), 64'd5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h4005, 32'h4006, 32'hA14, 2'd1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid0", 64'(out_valid_0), 64'd0);
    single(32'h0000_ABCD, 32'h900, 2'd0);
    chk("post_flush_inst0", 64'(inst_0), 64'hABCD);
    chk("post_flush_pc0",   64'(pc_0), 64'h900);

    // Reset mid-stream, rst beats flush and push
    dual(32'h5000, 32'h5001, 32'hB00, 2'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h5002, 32'h5003, 32'hB08, 2'd0);
    chk("midrst_count", 64'(count), 64'd0);
    single(32'h6000, 32'hC00, 2'd0);
    chk("after_rst_inst0", 64'(inst_0), 64'h6000);
    chk("after_rst_count", 64'(count), 64'd1);
    idle(2'd0);
    idle(2'd1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
